// File: rtl/controllo_pkg.sv
// Shared types and codes for the multicycle controller: FSM states,
// ALUControl encodings, data-processing cmd codes and condition codes.
package controllo_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9
    } stato_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/controllo_multiciclo_valuta_condizione.sv
// Combinational ARM condition evaluator: CondEx is 1 when Cond holds for
// the given {N,Z,C,V}; the reserved code 1111 never holds.
module valuta_condizione
    import controllo_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] NZCV,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = NZCV[3];
    assign z = NZCV[2];
    assign c = NZCV[1];
    assign v = NZCV[0];

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = ~(n ^ v);
            COND_LT: CondEx = n ^ v;
            COND_GT: CondEx = ~z & ~(n ^ v);
            COND_LE: CondEx = z | (n ^ v);
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/controllo_multiciclo.sv
// Multicycle ARM-subset control unit: Moore FSM sequencing fetch, decode,
// memory, data-processing and branch steps, plus the NZCV and CondEx registers.
module controllo_multiciclo
    import controllo_pkg::*;
#(
    parameter int ALUCTRL_W   = 2,
    parameter bit HAS_NOWRITE = 1'b1
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [3:0]           Cond,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [3:0]           ALUFlags,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 AdrSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [1:0]           RegSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic [3:0]           state_dbg,
    output logic [3:0]           nzcv_dbg,
    output logic                 cond_ex_dbg
);

    stato_t     state, state_next;
    logic [3:0] nzcv;
    logic       cond_ex, cond_ex_reg;

    logic [2:0] dp_alu, alu_sel;
    logic       dp_sup, dp_arith, dp_nowrite, wb_ok;
    logic       pc_w, ir_w, mem_w, reg_w;

    valuta_condizione u_cond (
        .Cond   (Cond),
        .NZCV   (nzcv),
        .CondEx (cond_ex)
    );

    // cmd decode; codes not available in this configuration fall back to ADD
    // and are marked unsupported so ALUWB never writes their result.
    always_comb begin
        dp_alu     = ALU_ADD;
        dp_sup     = 1'b0;
        dp_arith   = 1'b0;
        dp_nowrite = 1'b0;
        case (Funct[4:1])
            CMD_ADD: begin dp_alu = ALU_ADD; dp_sup = 1'b1; dp_arith = 1'b1; end
            CMD_SUB: begin dp_alu = ALU_SUB; dp_sup = 1'b1; dp_arith = 1'b1; end
            CMD_AND: begin dp_alu = ALU_AND; dp_sup = 1'b1; end
            CMD_ORR: begin dp_alu = ALU_ORR; dp_sup = 1'b1; end
            CMD_CMP: if (HAS_NOWRITE) begin
                dp_alu = ALU_SUB; dp_sup = 1'b1; dp_arith = 1'b1; dp_nowrite = 1'b1;
            end
            CMD_EOR: if (ALUCTRL_W == 3) begin dp_alu = ALU_EOR; dp_sup = 1'b1; end
            CMD_MOV: if (ALUCTRL_W == 3) begin dp_alu = ALU_MOV; dp_sup = 1'b1; end
            default: ;
        endcase
    end

    assign wb_ok = cond_ex_reg & dp_sup & ~dp_nowrite;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= S_FETCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:    state_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Op)
                    OP_MEM:  state_next = S_MEMADR;
                    OP_DP:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    OP_BR:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = MemReady ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = MemReady ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    always_comb begin
        pc_w      = 1'b0;
        ir_w      = 1'b0;
        mem_w     = 1'b0;
        reg_w     = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        alu_sel   = ALU_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
                ir_w = MemReady; pc_w = MemReady;
            end
            S_DECODE:   begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
            S_MEMADR:   ALUSrcB = 2'b01;
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB:    begin ResultSrc = 2'b01; reg_w = cond_ex_reg; end
            S_MEMWRITE: begin AdrSrc = 1'b1; mem_w = cond_ex_reg; end
            S_EXECUTER: alu_sel = dp_alu;
            S_EXECUTEI: begin ALUSrcB = 2'b01; alu_sel = dp_alu; end
            S_ALUWB:    begin reg_w = wb_ok; pc_w = wb_ok & (Rd == 4'd15); end
            S_BRANCH: begin
                ALUSrcB = 2'b01; ResultSrc = 2'b10; pc_w = cond_ex_reg;
            end
            default: ;
        endcase
    end

    // Strobes are forced low while reset is held, even in FETCH with MemReady=1.
    assign PCWrite    = pc_w & RST_N;
    assign IRWrite    = ir_w & RST_N;
    assign MemWrite   = mem_w & RST_N;
    assign RegWrite   = reg_w & RST_N;
    assign ALUControl = ALUCTRL_W'(alu_sel);
    assign ImmSrc     = Op;
    assign RegSrc     = {Op == OP_MEM, Op == OP_BR};

    // CondEx is frozen at DECODE; flags update at the end of the execute step.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            nzcv        <= 4'b0000;
            cond_ex_reg <= 1'b0;
        end else begin
            if (state == S_DECODE) cond_ex_reg <= cond_ex;
            if ((state == S_EXECUTER || state == S_EXECUTEI) && cond_ex_reg && Funct[0]) begin
                nzcv[3:2] <= ALUFlags[3:2];
                if (dp_arith) nzcv[1:0] <= ALUFlags[1:0];
            end
        end
    end

    assign state_dbg   = state;
    assign nzcv_dbg    = nzcv;
    assign cond_ex_dbg = cond_ex_reg;

endmodule

// File: tb/tb_controllo_multiciclo.sv
// Bench for controllo_multiciclo: two instances (ALUControl width 2 and 3)
// checked cycle by cycle against a per-instruction expected-cycle model.
module tb_controllo_multiciclo;
    import controllo_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [3:0] Cond, Rd, ALUFlags;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       MemReady;

    logic       pcw2, irw2, mw2, rw2, adr2, sa2, ce2;
    logic [1:0] sb2, rs2, imm2, rsrc2, alu2;
    logic [3:0] st2, fl2;
    logic       pcw3, irw3, mw3, rw3, adr3, sa3, ce3;
    logic [1:0] sb3, rs3, imm3, rsrc3;
    logic [2:0] alu3;
    logic [3:0] st3, fl3;

    always #5 CLK = ~CLK;

    controllo_multiciclo #(.ALUCTRL_W(2), .HAS_NOWRITE(1'b1)) dut2 (
        .CLK(CLK), .RST_N(RST_N), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(pcw2), .IRWrite(irw2),
        .MemWrite(mw2), .RegWrite(rw2), .AdrSrc(adr2), .ALUSrcA(sa2), .ALUSrcB(sb2),
        .ResultSrc(rs2), .ImmSrc(imm2), .RegSrc(rsrc2), .ALUControl(alu2),
        .state_dbg(st2), .nzcv_dbg(fl2), .cond_ex_dbg(ce2));

    controllo_multiciclo #(.ALUCTRL_W(3), .HAS_NOWRITE(1'b1)) dut3 (
        .CLK(CLK), .RST_N(RST_N), .Cond(Cond), .Op(Op), .Funct(Funct), .Rd(Rd),
        .ALUFlags(ALUFlags), .MemReady(MemReady), .PCWrite(pcw3), .IRWrite(irw3),
        .MemWrite(mw3), .RegWrite(rw3), .AdrSrc(adr3), .ALUSrcA(sa3), .ALUSrcB(sb3),
        .ResultSrc(rs3), .ImmSrc(imm3), .RegSrc(rsrc3), .ALUControl(alu3),
        .state_dbg(st3), .nzcv_dbg(fl3), .cond_ex_dbg(ce3));

    // One expected clock cycle: inputs to apply plus outputs both DUTs must show.
    typedef struct packed {
        logic       mr;
        logic [3:0] af;
        stato_t     st;
        logic [3:0] fl;
        logic       cx;
        logic       pcw2, pcw3, irw, mw, rw2, rw3, adr, sa;
        logic [1:0] sb, rs, imm, rsrc;
        logic [2:0] alu2, alu3;
    } cyc_t;

    cyc_t exp_q[$];
    cyc_t e_cur;
    int   n_vec = 0;
    int   n_err = 0;
    logic [3:0] m_nzcv = 4'b0000;
    logic       m_cex  = 1'b0;
    logic       cap_branch_pcw, cap_rw2, cap_rw3, cap_pcw2;
    logic [1:0] cap_alu2;
    logic [2:0] cap_alu3;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ARM condition table: code[3:1] picks a predicate, code[0] inverts it.
    function automatic logic cond_holds(input logic [3:0] cc, input logic [3:0] f);
        logic n, z, c, v, r;
        n = f[3]; z = f[2]; c = f[1]; v = f[0];
        case (cc[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c & ~z;
            3'd5: r = (n == v);
            3'd6: r = ~z & (n == v);
            default: return (cc == 4'b1110);
        endcase
        return r ^ cc[0];
    endfunction

    function automatic void alu_of(input logic [3:0] cmd, input bit w3, output logic [2:0] code,
                                   output bit sup, output bit arith, output bit nowr);
        code = 3'd0; sup = 0; arith = 0; nowr = 0;
        case (cmd)
            4'b0100: begin code = 3'd0; sup = 1; arith = 1; end
            4'b0010: begin code = 3'd1; sup = 1; arith = 1; end
            4'b0000: begin code = 3'd2; sup = 1; end
            4'b1100: begin code = 3'd3; sup = 1; end
            4'b1010: begin code = 3'd1; sup = 1; arith = 1; nowr = 1; end
            4'b0001: if (w3) begin code = 3'd4; sup = 1; end
            4'b1101: if (w3) begin code = 3'd5; sup = 1; end
            default: ;
        endcase
    endfunction

    function automatic cyc_t base(input logic [1:0] op, input stato_t st, input logic [3:0] fl,
                                  input logic cx);
        cyc_t c;
        c = '0;
        c.st = st; c.fl = fl; c.cx = cx;
        c.imm = op; c.rsrc = {op == 2'b01, op == 2'b10};
        c.mr = 1'($urandom); c.af = 4'($urandom);
        return c;
    endfunction

    // Builds the whole expected cycle list for one instruction, then plays it.
    task automatic run_instr(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] cond,
                             input logic [3:0] rd, input int wf, input int wm,
                             input logic [3:0] xf, input int stop_at, output int ncyc);
        cyc_t plan[$];
        cyc_t c;
        logic [3:0] fl;
        logic cex;
        logic [2:0] a2, a3;
        bit s2, s3, ar, nw;
        int n;
        fl = m_nzcv;
        for (int i = 0; i <= wf; i++) begin
            c = base(op, S_FETCH, fl, m_cex);
            c.mr = (i == wf); c.irw = c.mr; c.pcw2 = c.mr; c.pcw3 = c.mr;
            c.sa = 1; c.sb = 2'b10; c.rs = 2'b10;
            plan.push_back(c);
        end
        c = base(op, S_DECODE, fl, m_cex);
        c.sa = 1; c.sb = 2'b10;
        plan.push_back(c);
        cex = cond_holds(cond, fl);
        case (op)
            2'b01: begin
                c = base(op, S_MEMADR, fl, cex); c.sb = 2'b01; plan.push_back(c);
                for (int i = 0; i <= wm; i++) begin
                    c = base(op, funct[0] ? S_MEMREAD : S_MEMWRITE, fl, cex);
                    c.mr = (i == wm); c.adr = 1; c.mw = funct[0] ? 1'b0 : cex;
                    plan.push_back(c);
                end
                if (funct[0]) begin
                    c = base(op, S_MEMWB, fl, cex); c.rs = 2'b01; c.rw2 = cex; c.rw3 = cex;
                    plan.push_back(c);
                end
            end
            2'b00: begin
                alu_of(funct[4:1], 1'b0, a2, s2, ar, nw);
                alu_of(funct[4:1], 1'b1, a3, s3, ar, nw);
                c = base(op, funct[5] ? S_EXECUTEI : S_EXECUTER, fl, cex);
                c.sb = funct[5] ? 2'b01 : 2'b00; c.alu2 = a2; c.alu3 = a3; c.af = xf;
                plan.push_back(c);
                if (cex && funct[0]) begin
                    fl[3:2] = xf[3:2];
                    if (ar) fl[1:0] = xf[1:0];
                end
                c = base(op, S_ALUWB, fl, cex);
                c.rw2 = cex & s2 & ~nw; c.rw3 = cex & s3 & ~nw;
                c.pcw2 = c.rw2 & (rd == 4'd15); c.pcw3 = c.rw3 & (rd == 4'd15);
                plan.push_back(c);
            end
            2'b10: begin
                c = base(op, S_BRANCH, fl, cex);
                c.sb = 2'b01; c.rs = 2'b10; c.pcw2 = cex; c.pcw3 = cex;
                plan.push_back(c);
            end
            default: ;
        endcase
        m_nzcv = fl;
        m_cex = cex;
        ncyc = plan.size();
        n = (stop_at > 0 && stop_at < plan.size()) ? stop_at : plan.size();
        Op = op; Funct = funct; Cond = cond; Rd = rd;
        for (int i = 0; i < n; i++) begin
            MemReady = plan[i].mr;
            ALUFlags = plan[i].af;
            exp_q.push_back(plan[i]);
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic cmp_inst(input string t, input cyc_t e, input bit w3, input logic pcw, irw, mw,
                            rw, adr, sa, ce, input logic [1:0] sb, rs, imm, rsrc,
                            input logic [2:0] alu, input logic [3:0] st, fl);
        chk({t, "state"}, st, e.st);
        chk({t, "nzcv"}, fl, e.fl);
        chk({t, "condex"}, ce, e.cx);
        chk({t, "PCWrite"}, pcw, w3 ? e.pcw3 : e.pcw2);
        chk({t, "IRWrite"}, irw, e.irw);
        chk({t, "MemWrite"}, mw, e.mw);
        chk({t, "RegWrite"}, rw, w3 ? e.rw3 : e.rw2);
        chk({t, "AdrSrc"}, adr, e.adr);
        chk({t, "ALUSrcA"}, sa, e.sa);
        chk({t, "ALUSrcB"}, sb, e.sb);
        chk({t, "ResultSrc"}, rs, e.rs);
        chk({t, "ImmSrc"}, imm, e.imm);
        chk({t, "RegSrc"}, rsrc, e.rsrc);
        chk({t, "ALUControl"}, alu, w3 ? e.alu3 : e.alu2);
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() != 0) begin
            e_cur = exp_q.pop_front();
            cmp_inst("w2.", e_cur, 1'b0, pcw2, irw2, mw2, rw2, adr2, sa2, ce2, sb2, rs2, imm2,
                     rsrc2, {1'b0, alu2}, st2, fl2);
            cmp_inst("w3.", e_cur, 1'b1, pcw3, irw3, mw3, rw3, adr3, sa3, ce3, sb3, rs3, imm3,
                     rsrc3, alu3, st3, fl3);
            if (e_cur.st == S_BRANCH) cap_branch_pcw = pcw2;
            if (e_cur.st == S_EXECUTER || e_cur.st == S_EXECUTEI) begin
                cap_alu2 = alu2; cap_alu3 = alu3;
            end
            if (e_cur.st == S_ALUWB) begin
                cap_rw2 = rw2; cap_rw3 = rw3; cap_pcw2 = pcw2;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ncyc;
        RST_N = 1'b0; MemReady = 1'b1; ALUFlags = 4'hF;
        Op = 2'b00; Funct = 6'd0; Cond = 4'b1110; Rd = 4'd0;
        @(negedge CLK); @(negedge CLK);
        chk("rst_pcw", pcw2, 4'd0);
        chk("rst_irw", irw2, 4'd0);
        chk("rst_state", st2, 4'd0);
        chk("rst_nzcv", fl2, 4'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        // ADD R1,R2,R3
        run_instr(2'b00, 6'b001000, 4'b1110, 4'd1, 0, 0, 4'h0, 0, ncyc);
        chk("add_cycles", 4'(ncyc), 4'd4);
        chk("add_rw", cap_rw2, 4'd1);
        // LDR with three stall cycles in MEMREAD
        run_instr(2'b01, 6'b011001, 4'b1110, 4'd2, 0, 3, 4'h0, 0, ncyc);
        chk("ldr_cycles", 4'(ncyc), 4'd8);
        // SUBS giving Z, then BEQ / BNE
        run_instr(2'b00, 6'b000101, 4'b1110, 4'd3, 0, 0, 4'b0100, 0, ncyc);
        chk("subs_nzcv", fl2, 4'b0100);
        chk("model_nzcv", m_nzcv, 4'b0100);
        run_instr(2'b10, 6'b000000, 4'b0000, 4'd0, 1, 0, 4'h0, 0, ncyc);
        chk("beq_pcw", cap_branch_pcw, 4'd1);
        run_instr(2'b10, 6'b000000, 4'b0001, 4'd0, 0, 0, 4'h0, 0, ncyc);
        chk("bne_pcw", cap_branch_pcw, 4'd0);
        // CMP writes flags only; ADD to R15 loads the PC
        run_instr(2'b00, 6'b010101, 4'b1110, 4'd4, 0, 0, 4'b1011, 0, ncyc);
        chk("cmp_nzcv", fl2, 4'b1011);
        chk("cmp_rw", cap_rw2, 4'd0);
        run_instr(2'b00, 6'b001000, 4'b1110, 4'd15, 0, 0, 4'h0, 0, ncyc);
        chk("r15_rw", cap_rw2, 4'd1);
        chk("r15_pcw", cap_pcw2, 4'd1);
        // EOR: supported only by the 3-bit ALUControl instance
        run_instr(2'b00, 6'b000010, 4'b1110, 4'd5, 0, 0, 4'h0, 0, ncyc);
        chk("eor_alu3", cap_alu3, 4'b0100);
        chk("eor_alu2", cap_alu2, 4'b0000);
        chk("eor_rw2", cap_rw2, 4'd0);
        chk("eor_rw3", cap_rw3, 4'd1);

        for (int k = 0; k < 200; k++) begin
            run_instr(2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), 4'($urandom), 0, ncyc);
        end

        // Reset mid-STR while MemReady is held low
        run_instr(2'b00, 6'b000101, 4'b1110, 4'd6, 0, 0, 4'b1100, 0, ncyc);
        run_instr(2'b01, 6'b001000, 4'b1110, 4'd7, 0, 6, 4'h0, 4, ncyc);
        MemReady = 1'b0;
        #2;
        chk("pre_rst_mw", mw2, 4'd1);
        chk("pre_rst_state", st2, 4'(S_MEMWRITE));
        RST_N = 1'b0;
        #1;
        chk("mid_rst_mw2", mw2, 4'd0);
        chk("mid_rst_mw3", mw3, 4'd0);
        chk("mid_rst_state", st2, 4'd0);
        chk("mid_rst_nzcv", fl2, 4'd0);
        m_nzcv = 4'b0000;
        m_cex = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        for (int k = 0; k < 20; k++) begin
            run_instr(2'($urandom), 6'($urandom), 4'($urandom), 4'($urandom),
                      $urandom_range(0, 2), $urandom_range(0, 2), 4'($urandom), 0, ncyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/controllo_multiciclo.md
CONTROLLO_MULTICICLO -- requirements
Module: controllo_multiciclo

Interface
REQ-001 Parameter ALUCTRL_W, default 2, ALUControl width; legal values 2 or 3.
REQ-002 Parameter HAS_NOWRITE, default 1, enables CMP (cmd 1010): SUB, flags written, register write suppressed.
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 RST_N  in  1  reset, asynchronous, active-low.
REQ-005 Cond  in  4  instruction condition field.
REQ-006 Op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 undefined.
REQ-007 Funct  in  6  {I, cmd[3:0], S}; for memory, Funct[0]=L (load).
REQ-008 Rd  in  4  destination register index.
REQ-009 ALUFlags  in  4  {N,Z,C,V} from datapath ALU, current cycle.
REQ-010 MemReady  in  1  memory handshake; access completes in a cycle where it is 1.
REQ-011 PCWrite  out  1  PC load enable.
REQ-012 IRWrite  out  1  instruction register load enable.
REQ-013 MemWrite  out  1  data memory write strobe.
REQ-014 RegWrite  out  1  register file write enable.
REQ-015 AdrSrc  out  1  0 = PC, 1 = ALU result as memory address.
REQ-016 ALUSrcA  out  1  0 = register A, 1 = PC.
REQ-017 ALUSrcB  out  2  00 register B, 01 extended immediate, 10 constant 4.
REQ-018 ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result direct.
REQ-019 ImmSrc  out  2  equals Op in every state.
REQ-020 RegSrc  out  2  RegSrc[1] = (Op==01), RegSrc[0] = (Op==10), every state.
REQ-021 ALUControl  out  ALUCTRL_W  00 ADD, 01 SUB, 10 AND, 11 ORR; when width 3: 100 EOR (cmd 0001), 101 MOV/pass-B (cmd 1101).

Function
REQ-022 FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH; Moore outputs, except where a MemReady/CondExReg gate is stated.
REQ-023 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10; IRWrite=PCWrite=MemReady; stay while MemReady=0, else go to DECODE.
REQ-024 DECODE: ALUSrcA=1, ALUSrcB=10, ADD; capture CondExReg = condition(Cond, NZCV).
REQ-025 DECODE next state: Op 01 goes to MEMADR; Op 00 goes to EXECUTEI if Funct[5]=1, else EXECUTER; Op 10 goes to BRANCH; Op 11 goes to FETCH, no side effects.
REQ-026 MEMADR: ALUSrcA=0, ALUSrcB=01, ADD; goes to MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-027 MEMREAD: AdrSrc=1; hold until MemReady=1, then go to MEMWB. MEMWB: ResultSrc=01, RegWrite=CondExReg, then go to FETCH.
REQ-028 MEMWRITE: AdrSrc=1, MemWrite=CondExReg for every wait cycle; go to FETCH on MemReady=1.
REQ-029 EXECUTER: ALUSrcA=0, ALUSrcB=00. EXECUTEI: ALUSrcA=0, ALUSrcB=01. Both decode ALUControl from cmd and go to ALUWB.
REQ-030 Unsupported cmd (including cmd 0001/1101 when ALUCTRL_W=2): ALUControl=ADD, RegWrite suppressed in ALUWB.
REQ-031 Flag update at the end of EXECUTER/EXECUTEI, only if CondExReg=1 and S=1: N,Z <= ALUFlags[3:2] always; C,V <= ALUFlags[1:0] only for ADD/SUB/CMP.
REQ-032 ALUWB: ResultSrc=00; RegWrite = CondExReg & ~NoWrite; PCWrite = same term & (Rd==15); then go to FETCH.
REQ-033 BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondExReg; then go to FETCH.
REQ-034 Condition codes 0000-1110 follow the ARM table (EQ..AL); 1111 evaluates to 0.
REQ-035 Outputs not listed for a state are 0, with ALUControl=ADD.

Reset
REQ-036 RST_N low: state <= FETCH, NZCV <= 0000, CondExReg <= 0, asynchronously.
REQ-037 While RST_N is low, PCWrite, IRWrite, MemWrite and RegWrite are 0 regardless of MemReady; reset asserted mid-instruction abandons that instruction.

Structure
REQ-038 Package controllo_pkg holds the state enum, ALUControl codes, cmd codes and condition codes.
REQ-039 Combinational sub-module valuta_condizione(Cond, NZCV -> CondEx); flag and CondExReg registers live in the top module.

Verification
REQ-040 ADD R1,R2,R3 (Op 00, Funct 001000, Cond 1110), MemReady=1 -> FETCH,DECODE,EXECUTER,ALUWB; RegWrite=1 only in ALUWB; 4 cycles total.
REQ-041 LDR (Funct 011001) with MemReady low for 3 cycles in MEMREAD -> state held 3 extra cycles; MemWB RegWrite=1 once.
REQ-042 SUBS producing Z (ALUFlags 0100), then BEQ (Cond 0000) -> PCWrite=1 in BRANCH; BNE -> PCWrite=0.
REQ-043 CMP (cmd 1010, S=1) with HAS_NOWRITE=1 -> flags updated, RegWrite=0 in ALUWB; ADD with Rd=15 -> PCWrite=RegWrite=1 in ALUWB.
REQ-044 RST_N pulsed low during MEMWRITE with MemReady=0 -> MemWrite drops at once, state FETCH, NZCV=0000.
REQ-045 ALUCTRL_W=3, cmd 0001 -> ALUControl=100; ALUCTRL_W=2, same cmd -> ALUControl=00, no RegWrite.
